// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the 5-stage pipeline. It owns the program counter
// and fetches one word at a time from instruction memory over a
// req/gnt/rvalid handshake that allows a single outstanding request. The
// fetched {pc, instruction} pair is presented on registered if_* outputs to
// the IF/ID pipeline register. A one-entry skid buffer absorbs a response
// that arrives while the output slot is held by a stall. A redirect from EX
// retargets the PC and squashes anything already fetched or in flight.
//
// Parameters:
//   RESET_PC       first PC fetched after reset
//   PC_STEP        sequential PC increment in bytes
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   stall_i        downstream stall; holds the if_* outputs
//   redirect_valid one-cycle taken branch/jump pulse from EX
//   redirect_pc    redirect target (bits [1:0] ignored)
//   imem_req       fetch request
//   imem_addr      word-aligned fetch byte address
//   imem_gnt       request accepted this cycle when imem_req=1
//   imem_rvalid    response valid
//   imem_rdata     response instruction word
//   if_pc          PC of the presented instruction
//   if_inst        presented instruction
//   if_valid       if_pc/if_inst are valid
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic {
        FETCH = 1'b0,   // may issue a request
        WAIT  = 1'b1    // one request accepted, waiting for its response
    } state_t;

    state_t      state;
    logic [31:0] pc_q;        // next address to fetch
    logic [31:0] req_pc;      // address of the request in flight
    logic        kill;        // in-flight response belongs to a squashed path
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;

    logic        fire;        // request accepted on this edge
    logic        deliver;     // a usable response arrives this cycle
    logic        slot_free;   // the output register may be overwritten
    logic        in_flight;   // a request is outstanding with no response yet

    // Requesting is held off while the output is stalled or the skid is full,
    // so there is always somewhere to put the response. Reset forces the
    // request low immediately, not just from the next edge.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        imem_req = 1'b0;
        if (!rst && state == FETCH && !(if_valid && stall_i) && !skid_valid) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_gnt;
    assign deliver   = (state == WAIT) && imem_rvalid && !kill;
    assign slot_free = !if_valid || !stall_i;
    assign in_flight = (state == WAIT) && !imem_rvalid;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc_q       <= RESET_PC;
            req_pc     <= RESET_PC;
            kill       <= 1'b0;
            skid_valid <= 1'b0;
            skid_pc    <= 32'h0;
            skid_inst  <= 32'h0;
            if_valid   <= 1'b0;
            if_pc      <= 32'h0;
            if_inst    <= 32'h0;
        end else if (redirect_valid) begin
            // Redirect wins over every other event on this edge. Whatever is
            // presented or buffered is on the wrong path and is discarded.
            pc_q       <= {redirect_pc[31:2], 2'b00};
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (in_flight || fire) begin
                // A response is still owed to us: stay in WAIT and swallow it.
                // If kill was already set it simply stays set.
                kill  <= 1'b1;
                state <= WAIT;
            end else begin
                // Nothing outstanding, or its response is arriving right now
                // and is dropped here.
                kill  <= 1'b0;
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (fire) begin
                        req_pc <= pc_q;
                        pc_q   <= pc_q + PC_STEP;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill  <= 1'b0;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase

            // Output slot: the skid is older than any new response, so it is
            // drained first.
            if (slot_free) begin
                if (skid_valid) begin
                    if_pc      <= skid_pc;
                    if_inst    <= skid_inst;
                    if_valid   <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (deliver) begin
                    if_pc    <= req_pc;
                    if_inst  <= imem_rdata;
                    if_valid <= 1'b1;
                end else begin
                    if_valid <= 1'b0;
                end
            end else if (deliver) begin
                skid_pc    <= req_pc;
                skid_inst  <= imem_rdata;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage CPU. Owns the program counter, fetches from instruction memory over a single-outstanding req/gnt/rvalid handshake, and presents a registered {if_pc, if_inst, if_valid} to the IF/ID pipeline register. Supports downstream stall with a 1-entry skid buffer and branch/jump redirect with squash of in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value fetched first after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
stall_i  in  1  downstream hazard stall; holds if_* outputs
redirect_valid  in  1  one-cycle pulse, taken branch/jump from EX
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
imem_req  out  1  fetch request
imem_addr  out  32  fetch byte address, word aligned
imem_gnt  in  1  request accepted this cycle when imem_req=1
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction word
if_pc  out  32  PC of presented instruction
if_inst  out  32  presented instruction
if_valid  out  1  if_pc/if_inst valid

Behaviour:
- Reset (async, immediate): pc_q=RESET_PC, state=FETCH, kill=0, skid empty, if_valid=0, if_pc=0, if_inst=0. imem_req is gated low while rst=1; imem_addr=pc_q.
- Memory protocol: request accepted on edge with imem_req&&imem_gnt. Exactly one rvalid per accepted request, at least 1 cycle after acceptance. Never more than one outstanding. imem_req/imem_addr stay stable until gnt.
- States:
  - FETCH: imem_req=1 unless (if_valid && stall_i) or skid full. On gnt: req_pc<=pc_q, pc_q<=pc_q+PC_STEP (mod 2^32), ->WAIT.
  - WAIT: imem_req=0. On rvalid: if kill, drop data, kill<=0, ->FETCH. Else deliver {req_pc, imem_rdata}, ->FETCH.
- Delivery: output slot is free when !if_valid || !stall_i.
  - Slot free: outputs load from skid if full (skid empties), else from delivered response, else if_valid<=0.
  - Slot not free: delivered response goes to skid (skid_valid<=1).
  - Consumption: downstream takes the instruction on any edge with if_valid && !stall_i.
- Latency: gnt at edge N, rvalid during cycle N+k. Instruction is visible on if_* from edge N+k+1 when unstalled.
- Back-to-back: gnt can arrive in the same cycle as the req assertion. Peak throughput is 1 instruction per 2 cycles.
- Redirect (priority over stall and all other events, same edge):
  - pc_q<=redirect_pc&~3, if_valid<=0, skid cleared, state->FETCH.
  - If a request is outstanding without rvalid this cycle, or gnt occurs this same cycle: kill<=1, state->WAIT.
  - If rvalid arrives this same cycle, that data is dropped and kill stays 0.
- Redirect while kill=1 and the response is still pending: kill stays 1, pc_q updates to the new target.
- stall_i with if_valid=0 has no effect.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.

Test Plan:
- Reset then free-run, gnt=1, rvalid 1 cycle later, stall_i=0 -> imem_addr sequence 0,4,8,...; if_pc 0,4,8 with if_inst matching memory and if_valid=1; if_* all 0 during reset.
- stall_i=1 for 5 cycles with if_pc=0x8 valid while a response for 0xC is in flight -> if_pc stays 0x8, response for 0xC lands in skid, imem_req=0; release stall -> 0xC then 0x10 presented in order, no loss or duplication.
- Redirect to 0x100 while fetch of 0x14 is outstanding, rvalid 3 cycles later -> 0x14 data dropped, if_valid=0 until 0x100 delivered, next imem_addr=0x100.
- Redirect in the same cycle as gnt for 0x20 -> 0x20 squashed; redirect to 0x203 fetches 0x200.
- Assert rst mid-WAIT -> outputs zero immediately; after release the first imem_addr is RESET_PC and the stale rvalid is not required.
- pc_q=0xFFFF_FFFC -> following fetch address 0x0000_0000.
